// File: rtl/fht_but_pipe_pkg.sv
// Shared constants for the Hartley butterfly datapath: rounding and
// overflow-handling modes plus the default operand widths.
package fht_but_pipe_pkg;
  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_AWAY  = 1;
  localparam int SAT_WRAP    = 0;
  localparam int SAT_CLAMP   = 1;
  localparam int DEF_D_BIT   = 17;
  localparam int DEF_W_BIT   = 12;
endpackage

// File: rtl/fht_round_sat.sv
// Combinational scale-down of a full-precision butterfly result to D_BIT,
// with floor or round-half-away rounding and clamp or wrap on overflow.
module fht_round_sat
  import fht_but_pipe_pkg::*;
#(
  parameter int D_BIT = DEF_D_BIT,
  parameter int W_BIT = DEF_W_BIT,
  parameter int ROUND = ROUND_AWAY,
  parameter int SAT   = SAT_CLAMP
) (
  input  logic signed [D_BIT+W_BIT:0] iVAL,
  input  logic                        iSCALE,
  output logic signed [D_BIT-1:0]     oY,
  output logic                        oOVF
);
  localparam int XW = D_BIT + W_BIT + 2;

  logic signed [XW-1:0] ext, mag, half, rnd, shf;
  logic [XW-D_BIT:0] hi;
  logic neg;
  int k;

  always_comb begin
    k    = (W_BIT - 2) + (iSCALE ? 1 : 0);
    ext  = XW'(iVAL);
    neg  = ext[XW-1];
    // One spare bit keeps |most negative input| representable.
    mag  = neg ? -ext : ext;
    half = XW'(1) <<< (k - 1);
    rnd  = (mag + half) >>> k;
    if (ROUND == ROUND_AWAY) begin
      shf = neg ? -rnd : rnd;
    end else begin
      shf = ext >>> k;
    end
    hi   = shf[XW-1:D_BIT-1];
    oOVF = ~((&hi) | ~(|hi));
    if (oOVF && (SAT != SAT_WRAP)) begin
      oY = shf[XW-1] ? {1'b1, {(D_BIT-1){1'b0}}} : {1'b0, {(D_BIT-1){1'b1}}};
    end else begin
      oY = shf[D_BIT-1:0];
    end
  end
endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage radix-2 Hartley butterfly: products, sum/difference, then
// round/saturate. Control bits ride alongside the data; iEN stalls all stages.
module fht_but_pipe
  import fht_but_pipe_pkg::*;
#(
  parameter int D_BIT = DEF_D_BIT,
  parameter int W_BIT = DEF_W_BIT,
  parameter int ROUND = ROUND_AWAY,
  parameter int SAT   = SAT_CLAMP
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iEN,
  input  logic                    iVALID,
  input  logic                    iBYP,
  input  logic                    iSCALE,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iCOS,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic                    iOVF_CLR,
  output logic                    oVALID,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1,
  output logic                    oOVF
);
  localparam int MW = D_BIT + W_BIT;
  localparam int PW = MW + 1;
  localparam int UN = W_BIT - 2;

  logic signed [MW-1:0] x0_e, x1_e, x2_e, cos_e, sin_e;
  logic signed [MW-1:0] a_d, a_q, p1_d, p1_q, p2_d, p2_q;
  logic signed [PW-1:0] sum_d, sum_q, dif_d, dif_q;
  logic signed [D_BIT-1:0] y0_d, y0_q, y1_d, y1_q, rs0_y, rs1_y;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic sc1_d, sc1_q, sc2_d, sc2_q;
  logic ovf_d, ovf_q, rs0_ovf, rs1_ovf;

  always_comb begin
    x0_e  = MW'(iX_0);
    x1_e  = MW'(iX_1);
    x2_e  = MW'(iX_2);
    cos_e = MW'(iCOS);
    sin_e = MW'(iSIN);

    v1_d  = iVALID;
    sc1_d = iSCALE;
    a_d   = x0_e <<< UN;
    if (iBYP) begin
      p1_d = x1_e <<< UN;
      p2_d = '0;
    end else begin
      p1_d = x1_e * cos_e;
      p2_d = x2_e * sin_e;
    end

    v2_d  = v1_q;
    sc2_d = sc1_q;
    sum_d = PW'(a_q) + PW'(p1_q) + PW'(p2_q);
    dif_d = PW'(a_q) - PW'(p1_q) - PW'(p2_q);

    v3_d  = v2_q;
    y0_d  = rs0_y;
    y1_d  = rs1_y;
    // Set dominates clear; only valid slots entering the output stage count.
    ovf_d = (ovf_q & ~iOVF_CLR) | (iEN & v2_q & (rs0_ovf | rs1_ovf));
  end

  fht_round_sat #(.D_BIT(D_BIT), .W_BIT(W_BIT), .ROUND(ROUND), .SAT(SAT)) u_rs_sum (
    .iVAL(sum_q), .iSCALE(sc2_q), .oY(rs0_y), .oOVF(rs0_ovf)
  );

  fht_round_sat #(.D_BIT(D_BIT), .W_BIT(W_BIT), .ROUND(ROUND), .SAT(SAT)) u_rs_dif (
    .iVAL(dif_q), .iSCALE(sc2_q), .oY(rs1_y), .oOVF(rs1_ovf)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      v1_q  <= 1'b0;
      sc1_q <= 1'b0;
      a_q   <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      v2_q  <= 1'b0;
      sc2_q <= 1'b0;
      sum_q <= '0;
      dif_q <= '0;
      v3_q  <= 1'b0;
      y0_q  <= '0;
      y1_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (iEN) begin
        v1_q  <= v1_d;
        sc1_q <= sc1_d;
        a_q   <= a_d;
        p1_q  <= p1_d;
        p2_q  <= p2_d;
        v2_q  <= v2_d;
        sc2_q <= sc2_d;
        sum_q <= sum_d;
        dif_q <= dif_d;
        v3_q  <= v3_d;
        y0_q  <= y0_d;
        y1_q  <= y1_d;
      end
    end
  end

  assign oVALID = v3_q;
  assign oY_0   = y0_q;
  assign oY_1   = y1_q;
  assign oOVF   = ovf_q;
endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed bench: a round/clamp instance and a floor/wrap instance share the
// same stimulus; every expected value below is worked out by hand.
module tb_fht_but_pipe;
  logic iCLK = 1'b0;
  logic iRESET, iEN, iVALID, iBYP, iSCALE, iOVF_CLR;
  logic signed [16:0] iX_0, iX_1, iX_2;
  logic signed [11:0] iCOS, iSIN;
  logic vA, ovfA, vB, ovfB;
  logic signed [16:0] y0A, y1A, y0B, y1B;
  int errors = 0;
  int checks = 0;

  always #5 iCLK = ~iCLK;

  fht_but_pipe #(.D_BIT(17), .W_BIT(12), .ROUND(1), .SAT(1)) dut_a (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iBYP(iBYP),
    .iSCALE(iSCALE), .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iCOS(iCOS),
    .iSIN(iSIN), .iOVF_CLR(iOVF_CLR), .oVALID(vA), .oY_0(y0A), .oY_1(y1A),
    .oOVF(ovfA)
  );

  fht_but_pipe #(.D_BIT(17), .W_BIT(12), .ROUND(0), .SAT(0)) dut_b (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iBYP(iBYP),
    .iSCALE(iSCALE), .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iCOS(iCOS),
    .iSIN(iSIN), .iOVF_CLR(iOVF_CLR), .oVALID(vB), .oY_0(y0B), .oY_1(y1B),
    .oOVF(ovfB)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int v, input int y0, input int y1);
    chk({tag, "_a_valid"}, {31'd0, vA}, v);
    chk({tag, "_a_y0"}, y0A, y0);
    chk({tag, "_a_y1"}, y1A, y1);
  endtask

  task automatic chk_b(input string tag, input int v, input int y0, input int y1);
    chk({tag, "_b_valid"}, {31'd0, vB}, v);
    chk({tag, "_b_y0"}, y0B, y0);
    chk({tag, "_b_y1"}, y1B, y1);
  endtask

  task automatic set_in(input int x0, input int x1, input int x2, input int c,
                        input int s, input logic byp, input logic scale, input logic valid);
    iX_0 = 17'(x0); iX_1 = 17'(x1); iX_2 = 17'(x2);
    iCOS = 12'(c);  iSIN = 12'(s);
    iBYP = byp; iSCALE = scale; iVALID = valid;
  endtask

  // One valid pair, then two idle slots so its result sits at the outputs.
  task automatic send(input int x0, input int x1, input int x2, input int c,
                      input int s, input logic byp, input logic scale);
    set_in(x0, x1, x2, c, s, byp, scale, 1'b1);
    tick();
    iVALID = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    iRESET = 1'b1; iEN = 1'b1; iOVF_CLR = 1'b0;
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_a("reset", 0, 0, 0);
    chk("reset_ovf", {31'd0, ovfA}, 0);
    iRESET = 1'b0;
    tick();

    set_in(100, 200, 0, 1024, 0, 1'b0, 1'b1, 1'b1);
    tick();
    iVALID = 1'b0;
    tick();
    chk("basic_latency", {31'd0, vA}, 0);
    tick();
    chk_a("basic", 1, 150, -50);
    chk_b("basic", 1, 150, -50);

    send(10, 4, 0, 0, 0, 1'b1, 1'b0);
    chk_a("bypass", 1, 14, 6);
    chk_b("bypass", 1, 14, 6);

    send(7, 1000, 500, 512, -512, 1'b0, 1'b0);
    chk_a("twiddle", 1, 257, -243);
    chk_b("twiddle", 1, 257, -243);

    send(3, 0, 0, 1024, 0, 1'b0, 1'b1);
    chk_a("round_pos", 1, 2, 2);
    chk_b("round_pos", 1, 1, 1);
    send(-3, 0, 0, 1024, 0, 1'b0, 1'b1);
    chk_a("round_neg", 1, -2, -2);
    chk_b("round_neg", 1, -2, -2);
    chk("no_ovf_yet", {31'd0, ovfA}, 0);

    send(65535, 65535, 0, 1024, 0, 1'b0, 1'b0);
    chk_a("sat_pos", 1, 65535, 0);
    chk_b("wrap_pos", 1, -2, 0);
    chk("sat_pos_ovf", {31'd0, ovfA}, 1);
    chk("wrap_pos_ovf", {31'd0, ovfB}, 1);
    tick(); tick();
    chk("ovf_sticky", {31'd0, ovfA}, 1);

    iEN = 1'b0; iOVF_CLR = 1'b1;
    tick();
    iOVF_CLR = 1'b0; iEN = 1'b1;
    chk("ovf_clr_in_stall", {31'd0, ovfA}, 0);
    chk("ovf_clr_in_stall_b", {31'd0, ovfB}, 0);

    set_in(65535, 65535, 0, 1024, 0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("invalid_no_ovf", {31'd0, ovfA}, 0);

    set_in(-65536, -65536, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
    tick();
    iVALID = 1'b0;
    tick();
    chk("pre_set_ovf", {31'd0, ovfA}, 0);
    iOVF_CLR = 1'b1;
    tick();
    iOVF_CLR = 1'b0;
    chk_a("sat_neg", 1, -65536, 0);
    chk_b("wrap_neg", 1, 0, 0);
    chk("set_beats_clr", {31'd0, ovfA}, 1);
    chk("set_beats_clr_b", {31'd0, ovfB}, 1);
    iOVF_CLR = 1'b1;
    tick();
    iOVF_CLR = 1'b0;
    chk("ovf_clr", {31'd0, ovfA}, 0);

    set_in(10, 1, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(20, 2, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(30, 3, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("b2b_s1", 1, 11, 9);
    iEN = 1'b0;
    set_in(40, 4, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("stall_c1", 1, 11, 9);
    tick();
    chk_a("stall_c2", 1, 11, 9);
    iEN = 1'b1;
    tick();
    chk_a("b2b_s2", 1, 22, 18);
    set_in(50, 5, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("b2b_s3", 1, 33, 27);
    iVALID = 1'b0;
    tick();
    chk_a("b2b_s4", 1, 44, 36);
    tick();
    chk_a("b2b_s5", 1, 55, 45);
    chk_b("b2b_s5", 1, 55, 45);
    tick();
    chk("b2b_drain", {31'd0, vA}, 0);

    set_in(10, 1, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(20, 2, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(30, 3, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick();
    iVALID = 1'b0;
    chk_a("pre_reset", 1, 11, 9);
    #2;
    iRESET = 1'b1;
    #1;
    chk_a("async_reset", 0, 0, 0);
    chk_b("async_reset", 0, 0, 0);
    tick();
    iRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", {31'd0, vA}, 0);
    end
    send(10, 4, 0, 0, 0, 1'b1, 1'b0);
    chk_a("post_reset", 1, 14, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
